// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired control unit for the Datapath.
//                - Fetch runs in T0-T2, one clock per step.
//                - Opcode-specific execute steps run in T3-T7.
//                - Control strobes are decoded combinationally from the
//                  step register and IR[31:27].
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer #(
   parameter int              OP_W    = 5,
   parameter logic [OP_W-1:0] ALU_ADD = 5'b00011,
   parameter logic [OP_W-1:0] ALU_AND = 5'b01010,
   parameter logic [OP_W-1:0] ALU_OR  = 5'b01011
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [31:0]     IR,
   output logic            PC_out,
   output logic            MAR_enable,
   output logic            Read,
   output logic            MDR_enable,
   output logic            MDR_out,
   output logic            IR_enable,
   output logic            IncPC,
   output logic            PC_enable,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            R_in,
   output logic            R_out,
   output logic            BA_out,
   output logic            Y_enable,
   output logic            Z_enable,
   output logic            ZLow_out,
   output logic            C_out,
   output logic            HI_out,
   output logic            LO_out,
   output logic            in_port_out,
   output logic            out_port_enable,
   output logic            RAM_write_enable,
   output logic [OP_W-1:0] opcode,
   output logic            run
);

   // Opcode map
   localparam logic [OP_W-1:0] c_OP_LD   = OP_W'(5'b00000);
   localparam logic [OP_W-1:0] c_OP_LDI  = OP_W'(5'b00001);
   localparam logic [OP_W-1:0] c_OP_ST   = OP_W'(5'b00010);
   localparam logic [OP_W-1:0] c_OP_ADD  = OP_W'(5'b00011);
   localparam logic [OP_W-1:0] c_OP_SUB  = OP_W'(5'b00100);
   localparam logic [OP_W-1:0] c_OP_AND  = OP_W'(5'b01010);
   localparam logic [OP_W-1:0] c_OP_OR   = OP_W'(5'b01011);
   localparam logic [OP_W-1:0] c_OP_ADDI = OP_W'(5'b01100);
   localparam logic [OP_W-1:0] c_OP_ANDI = OP_W'(5'b01101);
   localparam logic [OP_W-1:0] c_OP_ORI  = OP_W'(5'b01110);
   localparam logic [OP_W-1:0] c_OP_IN   = OP_W'(5'b10110);
   localparam logic [OP_W-1:0] c_OP_OUT  = OP_W'(5'b10111);
   localparam logic [OP_W-1:0] c_OP_MFHI = OP_W'(5'b11000);
   localparam logic [OP_W-1:0] c_OP_MFLO = OP_W'(5'b11001);
   localparam logic [OP_W-1:0] c_OP_HALT = OP_W'(5'b11011);

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_T7    = 4'd8,
      S_HALT  = 4'd9
   } state_t;

   state_t          r_state;
   logic [OP_W-1:0] w_op;
   logic            w_is_rtype;
   logic            w_is_imm;
   logic            w_is_mem;
   logic            w_is_ld;
   logic [OP_W-1:0] w_imm_alu;
   logic            w_unused_ir;

   assign w_op        = IR[31 -: OP_W];
   // Only the opcode field steers sequencing; operand fields go to the Datapath.
   assign w_unused_ir = ^IR[31-OP_W:0];

   // Instruction class decode
   assign w_is_rtype = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) ||
                       (w_op == c_OP_AND) || (w_op == c_OP_OR);
   assign w_is_imm   = (w_op == c_OP_ADDI) || (w_op == c_OP_ANDI) ||
                       (w_op == c_OP_ORI)  || (w_op == c_OP_LDI);
   assign w_is_ld    = (w_op == c_OP_LD);
   assign w_is_mem   = w_is_ld || (w_op == c_OP_ST);

   // ALU code for immediate forms; ldi computes an address-style add
   always_comb begin
      w_imm_alu = ALU_ADD;
      if (w_op == c_OP_ANDI) w_imm_alu = ALU_AND;
      else if (w_op == c_OP_ORI) w_imm_alu = ALU_OR;
   end

   // Step sequencing: fetch, then execute length chosen by instruction class
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_RESET;
      end else begin
         case (r_state)
            S_RESET: r_state <= S_T0;
            S_T0:    r_state <= S_T1;
            S_T1:    r_state <= S_T2;
            S_T2:    r_state <= S_T3;
            S_T3: begin
               if (w_op == c_OP_HALT)
                  r_state <= S_HALT;
               else if (w_is_rtype || w_is_imm || w_is_mem)
                  r_state <= S_T4;
               else
                  r_state <= S_T0;
            end
            S_T4:    r_state <= S_T5;
            S_T5:    r_state <= w_is_mem ? S_T6 : S_T0;
            S_T6:    r_state <= S_T7;
            S_T7:    r_state <= S_T0;
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_RESET;
         endcase
      end
   end

   // Control strobe decode from current step and opcode
   always_comb begin
      PC_out           = 1'b0;
      MAR_enable       = 1'b0;
      Read             = 1'b0;
      MDR_enable       = 1'b0;
      MDR_out          = 1'b0;
      IR_enable        = 1'b0;
      IncPC            = 1'b0;
      PC_enable        = 1'b0;
      Gra              = 1'b0;
      Grb              = 1'b0;
      Grc              = 1'b0;
      R_in             = 1'b0;
      R_out            = 1'b0;
      BA_out           = 1'b0;
      Y_enable         = 1'b0;
      Z_enable         = 1'b0;
      ZLow_out         = 1'b0;
      C_out            = 1'b0;
      HI_out           = 1'b0;
      LO_out           = 1'b0;
      in_port_out      = 1'b0;
      out_port_enable  = 1'b0;
      RAM_write_enable = 1'b0;
      opcode           = '0;
      run              = (r_state != S_RESET) && (r_state != S_HALT);

      case (r_state)
         S_T0: begin
            PC_out     = 1'b1;
            MAR_enable = 1'b1;
         end
         S_T1: begin
            Read       = 1'b1;
            MDR_enable = 1'b1;
            IncPC      = 1'b1;
            PC_enable  = 1'b1;
         end
         S_T2: begin
            MDR_out   = 1'b1;
            IR_enable = 1'b1;
         end
         S_T3: begin
            if (w_is_rtype || w_is_imm || w_is_mem) begin
               // ldi and memory ops read base through BA so R0 reads as zero
               Grb      = 1'b1;
               Y_enable = 1'b1;
               if (w_is_mem || (w_op == c_OP_LDI)) BA_out = 1'b1;
               else                                R_out  = 1'b1;
            end else if (w_op == c_OP_MFHI) begin
               HI_out = 1'b1;
               Gra    = 1'b1;
               R_in   = 1'b1;
            end else if (w_op == c_OP_MFLO) begin
               LO_out = 1'b1;
               Gra    = 1'b1;
               R_in   = 1'b1;
            end else if (w_op == c_OP_IN) begin
               in_port_out = 1'b1;
               Gra         = 1'b1;
               R_in        = 1'b1;
            end else if (w_op == c_OP_OUT) begin
               Gra             = 1'b1;
               R_out           = 1'b1;
               out_port_enable = 1'b1;
            end
         end
         S_T4: begin
            Z_enable = 1'b1;
            if (w_is_rtype) begin
               Grc    = 1'b1;
               R_out  = 1'b1;
               opcode = w_op;
            end else if (w_is_imm) begin
               C_out  = 1'b1;
               opcode = w_imm_alu;
            end else begin
               C_out  = 1'b1;
               opcode = ALU_ADD;
            end
         end
         S_T5: begin
            ZLow_out = 1'b1;
            if (w_is_mem) begin
               MAR_enable = 1'b1;
            end else begin
               Gra  = 1'b1;
               R_in = 1'b1;
            end
         end
         S_T6: begin
            MDR_enable = 1'b1;
            if (w_is_ld) begin
               Read = 1'b1;
            end else begin
               Gra   = 1'b1;
               R_out = 1'b1;
            end
         end
         S_T7: begin
            if (w_is_ld) begin
               MDR_out = 1'b1;
               Gra     = 1'b1;
               R_in    = 1'b1;
            end else begin
               RAM_write_enable = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire
